combine_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered AND/OR combine unit among `NREQ` requesters. Each requester presents two operands and an operation select. The block grants one requester at a time, computes the result in a single execute cycle, and returns the result with the requester's ID over a valid/ready interface. It replaces per-requester AND/OR combine instances when area matters more than throughput.

---
 rtl/combine_arbiter.sv | 104 ++++++++++
 tb/tb_combine_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/combine_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR unit; capture->gnt 1 cycle, res_valid 2 cycles, 3 cycles/txn.
// Result is held in RESP until res_ready; req is ignored while busy. Optional xfer_cnt under COMBINE_ARB_CNT_EN.
module combine_arbiter #(
  parameter int IDW   = 2,
  parameter int WIDTH = 8,
  localparam int NREQ = 2**IDW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready
`ifdef COMBINE_ARB_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_last_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_op;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic               w_capture;

  // Search starts just past the previous winner; k == NREQ wraps back onto it.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[r_last_id + IDW'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last_id + IDW'(k);
      end
    end
  end

  assign w_capture = (r_state == S_IDLE) && w_found;
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_RESP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      r_last_id <= '1;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      gnt <= '0;
      if (w_capture) begin
        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        r_a       <= a_in[w_win*WIDTH +: WIDTH];
        r_b       <= b_in[w_win*WIDTH +: WIDTH];
        r_op      <= op[w_win];
        r_last_id <= w_win;
      end
      // r_last_id doubles as the in-flight owner ID until the next capture.
      if (r_state == S_EXEC) begin
        res_data <= r_op ? (r_a | r_b) : (r_a & r_b);
        res_id   <= r_last_id;
      end
    end
  end

`ifdef COMBINE_ARB_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      xfer_cnt <= '0;
    else if (res_valid && res_ready && (xfer_cnt != 16'hFFFF))
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_combine_arbiter.sv
// Directed plus randomized bench for combine_arbiter (IDW=2, WIDTH=8) against a queue-free behavioural model.
module tb_combine_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
`ifdef COMBINE_ARB_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = 3;
  int tb_xfers = 0;

  combine_arbiter #(.IDW(2), .WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op(op),
    .a_in(a_in), .b_in(b_in), .gnt(gnt), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready)
`ifdef COMBINE_ARB_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = '0; op = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_last = 3;
    tb_xfers = 0;
  endtask

  // Entered at the negedge of an IDLE cycle with req already applied; returns at the next IDLE negedge.
  task automatic run_txn(input int stall, output logic [7:0] d, output logic [1:0] id);
    int w;
    logic [7:0] er;
    logic [3:0] s_req, s_op;
    logic [31:0] s_a, s_b;
    w  = model_winner(req, model_last);
    er = op[w] ? (a_in[w*8 +: 8] | b_in[w*8 +: 8]) : (a_in[w*8 +: 8] & b_in[w*8 +: 8]);
    res_ready = (stall == 0);
    @(negedge clock);
    chk("gnt_onehot", gnt, 32'(1) << w);
    chk("busy_exec", busy, 1);
    chk("valid_exec", res_valid, 0);
    req[w] = 1'b0;
    @(negedge clock);
    chk("valid_resp", res_valid, 1);
    chk("gnt_resp", gnt, 0);
    chk("res_data", res_data, er);
    chk("res_id", res_id, w);
    d = res_data; id = res_id;
    s_req = req; s_op = op; s_a = a_in; s_b = b_in;
    for (int s = 0; s < stall; s++) begin
      req  = req ^ 4'b0010;
      a_in = $urandom; b_in = $urandom; op = 4'($urandom);
      @(negedge clock);
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, er);
      chk("stall_id", res_id, w);
      chk("stall_gnt", gnt, 0);
    end
    req = s_req; op = s_op; a_in = s_a; b_in = s_b;
    res_ready = 1'b1;
    @(negedge clock);
    chk("idle_valid", res_valid, 0);
    chk("idle_busy", busy, 0);
    model_last = w;
    tb_xfers++;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] id;
    reset_n = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single AND on requester 2
    @(negedge clock);
    req = 4'b0100; op = 4'b0000;
    a_in = $urandom; b_in = $urandom;
    a_in[23:16] = 8'hF0; b_in[23:16] = 8'h3C;
    run_txn(0, d, id);
    chk("and_data", d, 8'h30);
    chk("and_id", id, 2);

    // Reset asserted mid-RESP clears everything immediately
    req = 4'b0001; res_ready = 1'b0; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
    @(negedge clock);
    req = '0;
    @(negedge clock);
    chk("pre_rst_valid", res_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", res_data, 0);
    chk("midrst_gnt", gnt, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1; res_ready = 1'b1; model_last = 3; tb_xfers = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("idle_gnt", gnt, 0);
      chk("idle_busy10", busy, 0);
      chk("idle_valid10", res_valid, 0);
    end

    // Round-robin ORs
    req = 4'b1111; op = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_in[i*8 +: 8] = 8'h01 << i;
      b_in[i*8 +: 8] = 8'h80;
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(0, d, id);
      chk("rr_id", id, i);
      chk("rr_data", d, 8'h80 | (8'h01 << i));
    end

    // Backpressure, then immediate re-grant
    req = 4'b0010;
    run_txn(5, d, id);
    chk("bp_id", id, 1);
    req = 4'b0010;
    run_txn(0, d, id);
    chk("bp_regrant_id", id, 1);

    // Fairness after a single use of requester 3
    do_reset();
    req = 4'b1000;
    run_txn(0, d, id);
    chk("fair_first", id, 3);
    req = 4'b1001;
    run_txn(0, d, id);
    chk("fair_second", id, 0);
    run_txn(0, d, id);
    chk("fair_third", id, 3);
`ifdef COMBINE_ARB_CNT_EN
    chk("cnt_three", xfer_cnt, 3);
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (req == 4'b0000) begin
        a_in = $urandom; b_in = $urandom; op = 4'($urandom);
        req  = 4'($urandom_range(0, 15));
        if (req == 4'b0000) begin
          @(negedge clock);
          chk("rand_idle_busy", busy, 0);
          continue;
        end
      end
      run_txn($urandom_range(0, 3), d, id);
    end
    req = '0;

`ifdef COMBINE_ARB_CNT_EN
    chk("cnt_total", xfer_cnt, tb_xfers);
    @(negedge clock);
    force dut.xfer_cnt = 16'hFFFF;
    #1 release dut.xfer_cnt;
    @(negedge clock);
    req = 4'b0100;
    run_txn(0, d, id);
    chk("cnt_saturate", xfer_cnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
